alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_if.sv | 26 ++
 rtl/alu_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_if.sv
// Request/ALU bundle between the accumulator controller and its environment.
// slave = controller side, master = requester/ALU side.
interface alu_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [7:0] req_data;
  logic [3:0] alus;
  logic [7:0] ac_out;
  logic [7:0] bus_out;
  logic [7:0] alu_dout;
  logic       done;
  logic [7:0] result;
  logic       zf;
  logic       err;

  modport slave (
    input  req_valid, req_op, req_data, alu_dout,
    output req_ready, alus, ac_out, bus_out, done, result, zf, err
  );

  modport master (
    output req_valid, req_op, req_data, alu_dout,
    input  req_ready, alus, ac_out, bus_out, done, result, zf, err
  );
endinterface

// File: rtl/alu_ctrl.sv
// Accumulator controller sequencing an external 8-bit ALU (LDA, ALU ops, MUL).
// Macro ALU_CTRL_MUL_EN enables op 9 as shift-free repeated-add multiply.
module alu_ctrl (
  input  logic        clk,
  input  logic        rst,
  alu_ctrl_if.slave   ctl
);

`ifdef ALU_CTRL_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t     state_q, state_d;
  logic [7:0] ac_q, ac_d;
  logic [7:0] operand_q, operand_d;
  logic [3:0] op_q, op_d;
  logic       err_q, err_d;
  logic [3:0] alus_s;
`ifdef ALU_CTRL_MUL_EN
  logic [7:0] mcand_q, mcand_d;
  logic [7:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ac_q      <= 8'h00;
      operand_q <= 8'h00;
      op_q      <= 4'h0;
      err_q     <= 1'b0;
`ifdef ALU_CTRL_MUL_EN
      mcand_q   <= 8'h00;
      cnt_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      ac_q      <= ac_d;
      operand_q <= operand_d;
      op_q      <= op_d;
      err_q     <= err_d;
`ifdef ALU_CTRL_MUL_EN
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ac_d      = ac_q;
    operand_d = operand_q;
    op_d      = op_q;
    err_d     = err_q;
    alus_s    = 4'b1000;
`ifdef ALU_CTRL_MUL_EN
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (ctl.req_valid) begin
          operand_d = ctl.req_data;
          op_d      = ctl.req_op;
          err_d     = 1'b0;
          if (ctl.req_op[3] == 1'b0) begin
            state_d = EXEC;
          end else if (ctl.req_op == 4'h8) begin
            ac_d    = ctl.req_data;
            state_d = DONE;
`ifdef ALU_CTRL_MUL_EN
          end else if (ctl.req_op == 4'h9) begin
            mcand_d = ac_q;
            cnt_d   = ctl.req_data;
            ac_d    = 8'h00;
            state_d = MUL;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        alus_s  = op_q;
        ac_d    = ctl.alu_dout;
        state_d = DONE;
      end
`ifdef ALU_CTRL_MUL_EN
      // Multiply by repeated ALU add of mcand, one add per remaining count.
      MUL: begin
        if (cnt_q != 8'h00) begin
          alus_s = 4'b0000;
          ac_d   = ctl.alu_dout;
          cnt_d  = cnt_q - 8'h01;
        end else begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ctl.req_ready = (state_q == IDLE);
  assign ctl.done      = (state_q == DONE);
  assign ctl.alus      = alus_s;
  assign ctl.ac_out    = ac_q;
  assign ctl.result    = ac_q;
  assign ctl.zf        = (ac_q == 8'h00);
  assign ctl.err       = err_q;
`ifdef ALU_CTRL_MUL_EN
  assign ctl.bus_out   = (state_q == MUL) ? mcand_q : operand_q;
`else
  assign ctl.bus_out   = operand_q;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: transaction-level model plus per-cycle compare.
module tb_alu_ctrl;
  logic clk;
  logic rst;
  alu_ctrl_if ifc ();

  alu_ctrl u_dut (.clk(clk), .rst(rst), .ctl(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ALU in the environment: 0 add,1 sub,2 and,3 or,4 xor,5 shl,6 shr,7 not, else pass bus.
  function automatic logic [7:0] alu_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'h0: alu_fn = a + b;
      4'h1: alu_fn = a - b;
      4'h2: alu_fn = a & b;
      4'h3: alu_fn = a | b;
      4'h4: alu_fn = a ^ b;
      4'h5: alu_fn = {a[6:0], 1'b0};
      4'h6: alu_fn = {1'b0, a[7:1]};
      4'h7: alu_fn = ~a;
      default: alu_fn = b;
    endcase
  endfunction

  always_comb ifc.alu_dout = alu_fn(ifc.alus, ifc.ac_out, ifc.bus_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: the accumulator/err/operand the spec says must be visible when idle,
  // plus the negedge index of the accept and of the expected done pulse.
  logic [7:0] exp_ac, exp_bus, exp_mcand;
  logic       exp_err;
  int         negc = 0;
  int         acc_n = -100;
  int         done_at = -100;
  int         cur_kind = 0;   // 0 exec, 1 lda/illegal, 2 mul
  logic [3:0] cur_op;
  int         cur_k = 0;
  bit         chk_en = 1'b0;

  task automatic model_reset();
    exp_ac = 8'h00; exp_bus = 8'h00; exp_err = 1'b0; exp_mcand = 8'h00;
    acc_n = -100; done_at = -100;
  endtask

  task automatic model_accept(input logic [3:0] op, input logic [7:0] d);
    int lat;
    acc_n   = negc;
    exp_err = 1'b0;
    exp_bus = d;
    cur_op  = op;
    if (op < 4'h8) begin
      exp_ac = alu_fn(op, exp_ac, d); lat = 2; cur_kind = 0;
    end else if (op == 4'h8) begin
      exp_ac = d; lat = 1; cur_kind = 1;
`ifdef ALU_CTRL_MUL_EN
    end else if (op == 4'h9) begin
      exp_mcand = exp_ac;
      cur_k     = int'(d);
      exp_ac    = 8'((int'(exp_ac) * int'(d)) % 256);
      lat       = cur_k + 2;
      cur_kind  = 2;
`endif
    end else begin
      exp_err = 1'b1; lat = 1; cur_kind = 1;
    end
    done_at = negc + lat;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    int  j;
    bit  in_op;
    negc = negc + 1;
    if (chk_en) begin
      in_op = (negc > acc_n) && (negc <= done_at);
      j     = negc - acc_n;
      chk("req_ready", ifc.req_ready, !in_op);
      chk("done", ifc.done, negc == done_at);
      chk("err", ifc.err, exp_err);
      if (negc == done_at) begin
        chk("result", ifc.result, exp_ac);
        chk("alus_done", ifc.alus, 4'b1000);
      end
      if (!in_op) begin
        chk("ac_idle", ifc.ac_out, exp_ac);
        chk("zf_idle", ifc.zf, exp_ac == 8'h00);
        chk("alus_idle", ifc.alus, 4'b1000);
        chk("bus_idle", ifc.bus_out, exp_bus);
      end else if (negc < done_at) begin
        if (cur_kind == 0) begin
          chk("alus_exec", ifc.alus, cur_op);
        end else if (cur_kind == 2) begin
          chk("ac_mul", ifc.ac_out, 8'((int'(exp_mcand) * (j - 1)) % 256));
          if (j <= cur_k) begin
            chk("alus_mul", ifc.alus, 4'b0000);
            chk("bus_mul", ifc.bus_out, exp_mcand);
          end else begin
            chk("alus_mul_end", ifc.alus, 4'b1000);
          end
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clk); #1;
    rst = 1'b1;
    ifc.req_valid = 1'b0;
    model_reset();
    repeat (cycles) begin @(negedge clk); #1; end
    rst = 1'b0;
  endtask

  // Issue one request; optionally keep req_valid asserted (with an LDA) while busy.
  task automatic run_op(input logic [3:0] op, input logic [7:0] d, input bit hold,
                        output logic [7:0] res, output int lat, output logic zf_o, output logic err_o);
    int t;
    int n;
    @(negedge clk); #1;
    t = 0;
    while (!ifc.req_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (t >= 50) chk("ready_timeout", 32'd0, 32'd1);
    ifc.req_valid = 1'b1; ifc.req_op = op; ifc.req_data = d;
    model_accept(op, d);
    n = negc;
    @(negedge clk); #1;
    if (hold) begin
      ifc.req_op = 4'h8; ifc.req_data = 8'h55;
    end else begin
      ifc.req_valid = 1'b0;
    end
    t = 0;
    while (!ifc.done && t < 300) begin @(negedge clk); #1; t++; end
    if (t >= 300) chk("done_timeout", 32'd0, 32'd1);
    lat = negc - n; res = ifc.result; zf_o = ifc.zf; err_o = ifc.err;
    ifc.req_valid = 1'b0;
  endtask

  task automatic op_chk(input string name, input logic [3:0] op, input logic [7:0] d, input bit hold,
                        input logic [7:0] e_res, input int e_lat, input logic e_err, input logic e_zf);
    logic [7:0] res; int lat; logic z; logic e;
    run_op(op, d, hold, res, lat, z, e);
    chk({name, "_res"}, res, e_res);
    chk({name, "_lat"}, lat, e_lat);
    chk({name, "_err"}, e, e_err);
    chk({name, "_zf"}, z, e_zf);
  endtask

  initial begin
    int dcount;
    rst = 1'b1;
    ifc.req_valid = 1'b0; ifc.req_op = 4'h0; ifc.req_data = 8'h00;
    model_reset();
    do_reset(2);
    chk("rst_ready", ifc.req_ready, 1'b1);
    chk("rst_done", ifc.done, 1'b0);
    chk("rst_alus", ifc.alus, 4'b1000);
    chk("rst_ac", ifc.ac_out, 8'h00);
    chk("rst_bus", ifc.bus_out, 8'h00);
    chk("rst_zf", ifc.zf, 1'b1);
    chk("rst_err", ifc.err, 1'b0);
    chk_en = 1'b1;

    op_chk("lda05", 4'h8, 8'h05, 1'b0, 8'h05, 1, 1'b0, 1'b0);
    op_chk("add03", 4'h0, 8'h03, 1'b0, 8'h08, 2, 1'b0, 1'b0);
    op_chk("lda03", 4'h8, 8'h03, 1'b0, 8'h03, 1, 1'b0, 1'b0);
    op_chk("sub05", 4'h1, 8'h05, 1'b0, 8'hFE, 2, 1'b0, 1'b0);
    op_chk("xorFE", 4'h4, 8'hFE, 1'b0, 8'h00, 2, 1'b0, 1'b1);
    op_chk("op7",   4'h7, 8'h00, 1'b0, 8'hFF, 2, 1'b0, 1'b0);
    op_chk("and0F", 4'h2, 8'h0F, 1'b0, 8'h0F, 2, 1'b0, 1'b0);
    op_chk("orF0",  4'h3, 8'hF0, 1'b0, 8'hFF, 2, 1'b0, 1'b0);
    op_chk("shl",   4'h5, 8'h00, 1'b0, 8'hFE, 2, 1'b0, 1'b0);
    op_chk("shr",   4'h6, 8'h00, 1'b1, 8'h7F, 2, 1'b0, 1'b0);

    op_chk("lda2A", 4'h8, 8'h2A, 1'b0, 8'h2A, 1, 1'b0, 1'b0);
    op_chk("illC",  4'hC, 8'h11, 1'b1, 8'h2A, 1, 1'b1, 1'b0);
    op_chk("add01", 4'h0, 8'h01, 1'b0, 8'h2B, 2, 1'b0, 1'b0);

`ifdef ALU_CTRL_MUL_EN
    op_chk("lda07", 4'h8, 8'h07, 1'b0, 8'h07, 1, 1'b0, 1'b0);
    op_chk("mul03", 4'h9, 8'h03, 1'b1, 8'h15, 5, 1'b0, 1'b0);
    op_chk("mul00", 4'h9, 8'h00, 1'b0, 8'h00, 2, 1'b0, 1'b1);
    op_chk("lda10", 4'h8, 8'h10, 1'b0, 8'h10, 1, 1'b0, 1'b0);
    op_chk("mul10", 4'h9, 8'h10, 1'b0, 8'h00, 18, 1'b0, 1'b1);
    op_chk("lda0B", 4'h8, 8'h0B, 1'b0, 8'h0B, 1, 1'b0, 1'b0);
    op_chk("mul05", 4'h9, 8'h05, 1'b0, 8'h37, 7, 1'b0, 1'b0);
`else
    op_chk("lda07", 4'h8, 8'h07, 1'b0, 8'h07, 1, 1'b0, 1'b0);
    op_chk("op9",   4'h9, 8'h03, 1'b1, 8'h07, 1, 1'b1, 1'b0);
`endif

    // Reset while an operation is in flight: no done pulse, AC cleared.
    @(negedge clk); #1;
    ifc.req_valid = 1'b1;
`ifdef ALU_CTRL_MUL_EN
    ifc.req_op = 4'h9; ifc.req_data = 8'h0A;
    model_accept(4'h9, 8'h0A);
    @(negedge clk); #1;
    ifc.req_valid = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
`else
    ifc.req_op = 4'h0; ifc.req_data = 8'h0A;
    model_accept(4'h0, 8'h0A);
    @(negedge clk); #1;
    ifc.req_valid = 1'b0;
`endif
    do_reset(1);
    chk("abort_ac", ifc.ac_out, 8'h00);
    chk("abort_ready", ifc.req_ready, 1'b1);
    dcount = 0;
    repeat (15) begin
      @(negedge clk); #1;
      if (ifc.done) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    op_chk("lda01", 4'h8, 8'h01, 1'b0, 8'h01, 1, 1'b0, 1'b0);
    op_chk("illF",  4'hF, 8'h99, 1'b0, 8'h01, 1, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
